// File: rtl/score_stats.sv
`default_nettype none
// ============================================================================
// Module   : score_stats
// Function : Snapshots both players' packed score banks and computes, per
//            player, the best (minimum) score and the floor-average score via
//            a sequential slot scan followed by a bit-serial restoring divider.
//            A winner code for the result display is derived from the averages.
// Revision : 1.0  initial release
// ============================================================================
module score_stats #(
  parameter int SLOTS   = 9,
  parameter int SCORE_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SLOTS*SCORE_W-1:0]   store1,
  input  logic [SLOTS*SCORE_W-1:0]   store2,
  input  logic [4:0]                 count1,
  input  logic [4:0]                 count2,
  output logic                       busy,
  output logic                       done,
  output logic [SCORE_W-1:0]         best1,
  output logic [SCORE_W-1:0]         best2,
  output logic [SCORE_W-1:0]         avg1,
  output logic [SCORE_W-1:0]         avg2,
  output logic                       valid1,
  output logic                       valid2,
  output logic [1:0]                 winner
);

  localparam int SUM_W   = SCORE_W + 4;
  localparam int DIV_CYC = SUM_W;
  localparam int BANK_W  = SLOTS * SCORE_W;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;    // slot index in SCAN, step count in DIV
  logic [1:0][BANK_W-1:0]        r_bank;   // snapshot, shifted down one slot per scan cycle
  logic [1:0][4:0]               r_eff;    // effective entry count (0 when out of range)
  logic [1:0][SUM_W-1:0]         r_sum;    // running sum, then dividend/quotient shift register
  logic [1:0][SCORE_W-1:0]       r_min;
  logic [1:0][4:0]               r_rem;    // divider partial remainder, always < effective count

  logic [1:0][4:0]               w_eff_in;
  logic [1:0][SCORE_W-1:0]       w_score;
  logic [1:0]                    w_take;
  logic [1:0][5:0]               w_shift;
  logic [1:0]                    w_ge;
  logic [1:0]                    w_valid;
  logic [1:0][SCORE_W-1:0]       w_avg;
  logic [1:0]                    w_winner;

  // Per-player combinational helpers: count validation, current slot, divider trial step
  always_comb begin
    w_eff_in[0] = ((count1 == 5'd0) || (count1 > 5'(SLOTS))) ? 5'd0 : count1;
    w_eff_in[1] = ((count2 == 5'd0) || (count2 > 5'(SLOTS))) ? 5'd0 : count2;
    for (int p = 0; p < 2; p++) begin
      w_score[p] = r_bank[p][SCORE_W-1:0];
      w_take[p]  = r_cnt < r_eff[p];
      w_shift[p] = {r_rem[p], r_sum[p][SUM_W-1]};
      w_ge[p]    = w_shift[p] >= {1'b0, r_eff[p]};
      w_valid[p] = r_eff[p] != 5'd0;
      // An empty bank never divides: its quotient is forced to zero here.
      w_avg[p]   = w_valid[p] ? r_sum[p][SCORE_W-1:0] : '0;
    end
  end

  // Winner: lower average wins when both have data, otherwise whoever has data
  always_comb begin
    w_winner = 2'b00;
    if (w_valid[0] && w_valid[1]) begin
      if (w_avg[0] < w_avg[1])      w_winner = 2'b01;
      else if (w_avg[1] < w_avg[0]) w_winner = 2'b10;
      else                          w_winner = 2'b11;
    end else if (w_valid[0]) begin
      w_winner = 2'b01;
    end else if (w_valid[1]) begin
      w_winner = 2'b10;
    end
  end

  // Control FSM with scan datapath, serial divider and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bank  <= '0;
      r_eff   <= '0;
      r_sum   <= '0;
      r_min   <= '0;
      r_rem   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      best1   <= '0;
      best2   <= '0;
      avg1    <= '0;
      avg2    <= '0;
      valid1  <= 1'b0;
      valid2  <= 1'b0;
      winner  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_bank[0] <= store1;
            r_bank[1] <= store2;
            r_eff     <= w_eff_in;
            r_sum     <= '0;
            r_min     <= '1;
            r_rem     <= '0;
            r_cnt     <= '0;
            busy      <= 1'b1;
            r_state   <= S_SCAN;
          end
        end

        S_SCAN: begin
          for (int p = 0; p < 2; p++) begin
            if (w_take[p]) begin
              r_sum[p] <= r_sum[p] + SUM_W'(w_score[p]);
              if (w_score[p] < r_min[p]) r_min[p] <= w_score[p];
            end
            r_bank[p] <= r_bank[p] >> SCORE_W;
          end
          if (r_cnt == CNT_W'(SLOTS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_DIV;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DIV: begin
          if (r_cnt == CNT_W'(DIV_CYC)) begin
            // Quotient is complete: publish results together with the done pulse.
            best1   <= w_valid[0] ? r_min[0] : '0;
            best2   <= w_valid[1] ? r_min[1] : '0;
            avg1    <= w_avg[0];
            avg2    <= w_avg[1];
            valid1  <= w_valid[0];
            valid2  <= w_valid[1];
            winner  <= w_winner;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            for (int p = 0; p < 2; p++) begin
              if (w_ge[p]) begin
                r_rem[p] <= 5'(w_shift[p] - {1'b0, r_eff[p]});
                r_sum[p] <= {r_sum[p][SUM_W-2:0], 1'b1};
              end else begin
                r_rem[p] <= w_shift[p][4:0];
                r_sum[p] <= {r_sum[p][SUM_W-2:0], 1'b0};
              end
            end
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_stats
// Function : Self-checking bench for score_stats with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_score_stats;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [89:0] store1 = '0;
  logic [89:0] store2 = '0;
  logic [4:0]  count1 = '0;
  logic [4:0]  count2 = '0;
  logic        busy, done, valid1, valid2;
  logic [9:0]  best1, best2, avg1, avg2;
  logic [1:0]  winner;

  int checks = 0;
  int passed = 0;

  score_stats dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .store1(store1), .store2(store2), .count1(count1), .count2(count2),
    .busy(busy), .done(done),
    .best1(best1), .best2(best2), .avg1(avg1), .avg2(avg2),
    .valid1(valid1), .valid2(valid2), .winner(winner)
  );

  always #5 clk = ~clk;

  // Reference: statistics of one bank computed directly from its entries
  function automatic void player_ref(input logic [89:0] s, input logic [4:0] c,
                                     output logic [9:0] b, output logic [9:0] a,
                                     output logic v);
    int n, sum, mn, sc;
    logic [89:0] tmp;
    n = (c == 0 || c > 9) ? 0 : int'(c);
    sum = 0;
    mn = 1023;
    tmp = s;
    for (int k = 0; k < n; k++) begin
      sc = int'(tmp[9:0]);
      tmp = tmp >> 10;
      sum += sc;
      if (sc < mn) mn = sc;
    end
    v = (n > 0);
    b = v ? 10'(mn) : 10'd0;
    a = v ? 10'(sum / n) : 10'd0;
  endfunction

  function automatic logic [1:0] winner_ref(input logic v1, input logic v2,
                                            input logic [9:0] a1, input logic [9:0] a2);
    if (v1 && v2) return (a1 < a2) ? 2'b01 : (a2 < a1) ? 2'b10 : 2'b11;
    if (v1) return 2'b01;
    if (v2) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [89:0] fill(input int v);
    logic [89:0] s;
    for (int k = 0; k < 9; k++) s[k*10 +: 10] = 10'(v);
    return s;
  endfunction

  function automatic logic [89:0] rand_bank();
    logic [89:0] s;
    for (int k = 0; k < 9; k++) s[k*10 +: 10] = 10'($urandom_range(0, 1023));
    return s;
  endfunction

  // One complete run: latency, busy/done timing and all results against the model
  task automatic run_check(input string nm, input logic [89:0] s1, input logic [89:0] s2,
                           input logic [4:0] c1, input logic [4:0] c2);
    logic [9:0] eb1, ea1, eb2, ea2;
    logic ev1, ev2;
    logic [1:0] ew;
    int cyc;
    player_ref(s1, c1, eb1, ea1, ev1);
    player_ref(s2, c2, eb2, ea2, ev2);
    ew = winner_ref(ev1, ev2, ea1, ea2);
    @(negedge clk);
    store1 = s1; store2 = s2; count1 = c1; count2 = c2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", nm, busy);
    else passed++;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 25) $display("FAIL %s latency: done in cycle %0d want 25", nm, cyc);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", nm, busy);
    else passed++;
    checks++;
    if (best1 !== eb1 || avg1 !== ea1 || valid1 !== ev1)
      $display("FAIL %s player1: got best=%0d avg=%0d valid=%b want best=%0d avg=%0d valid=%b",
               nm, best1, avg1, valid1, eb1, ea1, ev1);
    else passed++;
    checks++;
    if (best2 !== eb2 || avg2 !== ea2 || valid2 !== ev2)
      $display("FAIL %s player2: got best=%0d avg=%0d valid=%b want best=%0d avg=%0d valid=%b",
               nm, best2, avg2, valid2, eb2, ea2, ev2);
    else passed++;
    checks++;
    if (winner !== ew) $display("FAIL %s winner: got %b want %b", nm, winner, ew);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || best1 !== eb1 || avg2 !== ea2)
      $display("FAIL %s pulse_hold: got done=%b best1=%0d avg2=%0d want done=0 best1=%0d avg2=%0d",
               nm, done, best1, avg2, eb1, ea2);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, valid1, valid2, winner, best1, best2, avg1, avg2} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b v=%b%b w=%b b=%0d/%0d a=%0d/%0d want all 0",
               busy, done, valid1, valid2, winner, best1, best2, avg1, avg2);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [89:0] s1, s2;
    s1 = fill(999);
    s1[9:0] = 10'd250; s1[19:10] = 10'd180; s1[29:20] = 10'd310;
    s2 = rand_bank();
    s2[9:0] = 10'd200; s2[19:10] = 10'd201;
    run_check("mixed", s1, s2, 5'd3, 5'd2);
    run_check("all_max", fill(1023), fill(1023), 5'd9, 5'd9);
    run_check("no_data", rand_bank(), rand_bank(), 5'd0, 5'd12);
    s1 = rand_bank();
    s1[9:0] = 10'd400;
    run_check("single_p1", s1, rand_bank(), 5'd1, 5'd0);
    run_check("count_10", rand_bank(), rand_bank(), 5'd10, 5'd9);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_check("random", rand_bank(), rand_bank(),
                5'($urandom_range(0, 11)), 5'($urandom_range(1, 9)));
  endtask

  task automatic test_reset_mid_div();
    int dones;
    @(negedge clk);
    store1 = rand_bank(); store2 = rand_bank(); count1 = 5'd5; count2 = 5'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, valid1, valid2, winner, best1, best2, avg1, avg2} !== '0)
      $display("FAIL reset_mid_div: got busy=%b done=%b v=%b%b w=%b b=%0d/%0d a=%0d/%0d want all 0",
               busy, done, valid1, valid2, winner, best1, best2, avg1, avg2);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) $display("FAIL reset_abort_done: got %0d done pulses want 0", dones);
    else passed++;
    run_check("after_reset", rand_bank(), rand_bank(), 5'd4, 5'd4);
  endtask

  task automatic test_start_while_busy();
    logic [89:0] s1, s2;
    logic [9:0] eb1, ea1, eb2, ea2;
    logic ev1, ev2;
    int cyc, dones;
    s1 = rand_bank(); s2 = rand_bank();
    player_ref(s1, 5'd9, eb1, ea1, ev1);
    player_ref(s2, 5'd7, eb2, ea2, ev2);
    @(negedge clk);
    store1 = s1; store2 = s2; count1 = 5'd9; count2 = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    dones = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin store1 = ~s1; count1 = 5'd2; end
      if (cyc == 5) start = 1'b1;
      if (cyc == 6) start = 1'b0;
      if (done) begin
        dones++;
        checks++;
        if (cyc !== 25 || best1 !== eb1 || avg1 !== ea1 || best2 !== eb2 || avg2 !== ea2)
          $display("FAIL snapshot: got cyc=%0d b1=%0d a1=%0d b2=%0d a2=%0d want cyc=25 b1=%0d a1=%0d b2=%0d a2=%0d",
                   cyc, best1, avg1, best2, avg2, eb1, ea1, eb2, ea2);
        else passed++;
      end
    end
    checks++;
    if (dones !== 1) $display("FAIL start_ignored: got %0d done pulses want 1", dones);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [89:0] s1, s2;
    logic [9:0] eb1, ea1, eb2, ea2;
    logic ev1, ev2;
    logic [1:0] ew;
    int c, n, last;
    s1 = rand_bank(); s2 = rand_bank();
    player_ref(s1, 5'd6, eb1, ea1, ev1);
    player_ref(s2, 5'd8, eb2, ea2, ev2);
    ew = winner_ref(ev1, ev2, ea1, ea2);
    @(negedge clk);
    store1 = s1; store2 = s2; count1 = 5'd6; count2 = 5'd8; start = 1'b1;
    c = 0; n = 0; last = 0;
    repeat (85) begin
      @(negedge clk);
      c++;
      if (done) begin
        n++;
        checks++;
        if ((n == 1 && c !== 25) || (n > 1 && c - last !== 26))
          $display("FAIL b2b_spacing: done #%0d at cycle %0d, previous %0d, want 25 then every 26",
                   n, c, last);
        else passed++;
        checks++;
        if (best1 !== eb1 || avg1 !== ea1 || best2 !== eb2 || avg2 !== ea2 || winner !== ew)
          $display("FAIL b2b_results: got b1=%0d a1=%0d b2=%0d a2=%0d w=%b want %0d %0d %0d %0d %b",
                   best1, avg1, best2, avg2, winner, eb1, ea1, eb2, ea2, ew);
        else passed++;
        last = c;
      end
    end
    checks++;
    if (n !== 3) $display("FAIL b2b_count: got %0d done pulses want 3", n);
    else passed++;
    start = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_div();
    test_start_while_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_stats.md
Name: score_stats

Overview:
- Downstream consumer of the per-player score store in the reaction timer.
- On a start request, snapshots both 90-bit packed score banks and their entry counts.
- Scans up to 9 slots per player sequentially, then runs a bit-serial divider to produce per-player best (minimum) and floor-average reaction times, plus a winner code for the result display.

Parameters:
- SLOTS, 9, number of 10-bit score slots per player bank.
- SCORE_W, 10, width of one score (ms).
- Derived, not overridable: SUM_W = SCORE_W+4 (14); DIV_CYC = SUM_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request statistics; sampled only in IDLE.
- store1  input  SLOTS*SCORE_W (90)  player-1 bank; slot k is bits [10k+9:10k], holding entry k+1.
- store2  input  90  player-2 bank, same packing.
- count1  input  5  number of valid player-1 entries.
- count2  input  5  number of valid player-2 entries.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results update.
- best1, best2  output  10  minimum valid score per player; 0 if no entries.
- avg1, avg2  output  10  floor(sum/count) per player; 0 if no entries.
- valid1, valid2  output  1  player has at least one valid entry.
- winner  output  2  00 no data, 01 player 1, 10 player 2, 11 tie.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; busy, done, valid1, valid2 = 0; best*, avg* = 0; winner = 00; internal snapshot, accumulators and divider cleared. Reset mid-operation aborts the run with no done pulse.
- FSM states: IDLE, SCAN, DIV, DONE.
- IDLE:
  - start=1 at a clock edge: snapshot store1, store2, count1, count2; clear accumulators (sum=0, min=10'h3FF, idx=0); go to SCAN.
  - start is ignored in every other state; a start held high re-triggers only after returning to IDLE.
- Count validation: an effective count of 0 applies when the count is 0 or greater than SLOTS.
- SCAN, one slot per cycle, idx 0..8, 9 cycles:
  - Slot idx contributes only if idx < effective count.
  - Contribution: sum += score (14-bit); min = score if score < min.
  - Both players are processed in parallel.
  - Exit to DIV after idx=8.
- DIV:
  - Restoring shift-subtract division of a 14-bit sum by a 5-bit effective count, both players in parallel, 14 cycles.
  - Quotient is truncated to 10 bits; it cannot exceed 1023 because sum ≤ count·1023.
  - Division by 0 is never performed: an effective count of 0 forces quotient 0.
- DONE, one cycle:
  - Register outputs and assert done=1; busy falls in the same cycle.
  - Return to IDLE next cycle.
  - best = min if valid, else 0. avg = quotient if valid, else 0.
  - winner rules:
    - Both valid: the lower avg wins; equal avg gives 11.
    - Only one valid: that player wins.
    - Neither valid: 00.
- Latency: done is high in the 25th cycle after the start edge (1 accept, 9 scan, 14 divide, 1 done). A new start is accepted in the cycle after done.
- Outputs hold their last values between runs. Input changes after the snapshot have no effect on the current run.

Test Plan:
- Reset during DIV (rst_n low at cycle 15 of a run) -> all outputs 0 immediately; no done pulse; next start completes normally.
- count1=3, store1 slots 0..2 = 250, 180, 310, slots 3..8 = 999; count2=2, store2 slots 0..1 = 200, 201 -> best1=180, avg1=246, best2=200, avg2=200, winner=10; done exactly 25 cycles after the start edge.
- count1=9, all slots 1023; count2=9, all slots 1023 -> avg1=avg2=1023, best=1023, winner=11 (no sum overflow at 9207).
- count1=0, count2=12, arbitrary stores -> valid1=valid2=0, best=avg=0, winner=00.
- count1=1, store1 slot 0 = 400; count2=0 -> avg1=400, best1=400, valid2=0, winner=01.
- start pulsed while busy, and store1 changed mid-scan -> no restart; results reflect the snapshot; start held high yields back-to-back runs, one done per 26 cycles.
